// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first.
// The rx pin goes through a two-flop synchronizer and each bit is sampled at
// mid-bit. Received bytes are presented through a one-entry valid/ready
// output register. Framing errors and overruns are flagged with one-cycle
// pulses.
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active-high
//   rx         asynchronous serial line, idles high
//   data       received byte, stable while valid=1
//   valid      data holds an unconsumed byte
//   ready      consumer accepts data when valid&ready at a rising edge
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, output register full
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | counting to mid start bit, confirming it is still low
// DATA      | sampling 8 data bits at mid-bit
// STOP      | waiting for mid stop bit, then deliver or flag framing error
// WAIT_HIGH | after a framing error, wait for the line to return high

module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 2_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
   localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_e;

   state_e      state_q, state_d;
   logic        rx_meta_q;
   logic        rx_s_q;
   logic [15:0] clk_count_q, clk_count_d;
   logic [2:0]  bit_index_q, bit_index_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        frame_err_q, frame_err_d;
   logic        overrun_q, overrun_d;
   logic        deliver;

   always_comb begin
      state_d     = state_q;
      clk_count_d = clk_count_q;
      bit_index_d = bit_index_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      deliver     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d     = START;
               clk_count_d = 16'd0;
            end
         end
         START: begin
            if (clk_count_q == HALF_LAST) begin
               if (!rx_s_q) begin
                  state_d     = DATA;
                  clk_count_d = 16'd0;
                  bit_index_d = 3'd0;
               end else begin
                  // start bit did not survive to mid-bit: treat as a glitch
                  state_d = IDLE;
               end
            end else begin
               clk_count_d = clk_count_q + 16'd1;
            end
         end
         DATA: begin
            if (clk_count_q == BIT_LAST) begin
               shift_d[bit_index_q] = rx_s_q;
               clk_count_d          = 16'd0;
               if (bit_index_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_index_d = bit_index_q + 3'd1;
               end
            end else begin
               clk_count_d = clk_count_q + 16'd1;
            end
         end
         STOP: begin
            if (clk_count_q == BIT_LAST) begin
               clk_count_d = 16'd0;
               // leaving at mid stop bit leaves half a bit of margin for the
               // next start edge of a back-to-back frame
               if (rx_s_q) begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_HIGH;
               end
            end else begin
               clk_count_d = clk_count_q + 16'd1;
            end
         end
         WAIT_HIGH: begin
            if (rx_s_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // a new byte takes priority over clearing valid on consumption
      if (deliver) begin
         if (!valid_q || ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= IDLE;
         clk_count_q <= 16'd0;
         bit_index_q <= 3'd0;
         shift_q     <= 8'd0;
         data_q      <= 8'd0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         state_q     <= state_d;
         clk_count_q <= clk_count_d;
         bit_index_q <= bit_index_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at default parameters (25 clk/bit).
// Edge k of a frame (edge 0 = first posedge after rx falls) is the (k+1)-th
// posedge after the sender drops rx, which happens 1 time unit after a posedge.

module tb_uart_rx;

   localparam int CPB = 25;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;

   int checks   = 0;
   int failures = 0;

   int         fe_cnt = 0;
   int         ov_cnt = 0;
   logic [7:0] acc_q[$];

   uart_rx dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pulse counters and accepted-byte log, sampled mid-cycle
   always @(negedge clk) begin
      if (!reset) begin
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (valid && ready) acc_q.push_back(data);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // called 1 time unit after a posedge; returns 1 time unit after a posedge
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx = stop_bit;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] acc_at(input int idx);
      if (acc_q.size() > idx) return {24'd0, acc_q[idx]};
      return 32'hDEAD;
   endfunction

   int fe0, ov0, a0;

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      ready = 1'b0;
      idle(4);
      reset = 1'b0;
      idle(1);
      check_val("rst_data", data, 8'h00);
      check_val("rst_valid", valid, 1'b0);
      check_val("rst_frame_err", frame_err, 1'b0);
      check_val("rst_overrun", overrun, 1'b0);
      idle(5);

      // 1: 0xA5, ready=1, valid exactly at edge 239 for one cycle
      ready = 1'b1;
      fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_q.size();
      fork
         send_byte(8'hA5, 1'b1);
         begin
            repeat (239) @(posedge clk);
            #1;
            check_val("t1_valid_e238", valid, 1'b0);
            @(posedge clk);
            #1;
            check_val("t1_valid_e239", valid, 1'b1);
            check_val("t1_data_e239", data, 8'hA5);
            @(posedge clk);
            #1;
            check_val("t1_valid_e240", valid, 1'b0);
         end
      join
      idle(5);
      check_val("t1_acc_cnt", acc_q.size() - a0, 1);
      check_val("t1_acc_byte", acc_at(a0), 8'hA5);
      check_val("t1_fe", fe_cnt - fe0, 0);
      check_val("t1_ov", ov_cnt - ov0, 0);

      // 2: 0x00 then 0xFF back-to-back with ready=0 -> one overrun
      ready = 1'b0;
      fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_q.size();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      check_val("t2_valid_held", valid, 1'b1);
      check_val("t2_data_held", data, 8'h00);
      check_val("t2_ov", ov_cnt - ov0, 1);
      check_val("t2_fe", fe_cnt - fe0, 0);
      ready = 1'b1;
      idle(1);
      check_val("t2_valid_clr", valid, 1'b0);
      ready = 1'b0;
      check_val("t2_acc_cnt", acc_q.size() - a0, 1);
      check_val("t2_acc_byte", acc_at(a0), 8'h00);
      idle(5);

      // 3: 0x3C then 0xC3, ready rises in the delivery cycle of 0xC3
      fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_q.size();
      fork
         begin
            send_byte(8'h3C, 1'b1);
            send_byte(8'hC3, 1'b1);
         end
         begin
            repeat (2 * 10 * CPB / 2 + 1 + 238) @(posedge clk);
            #1;
            check_val("t3_valid_pre", valid, 1'b1);
            check_val("t3_data_pre", data, 8'h3C);
            ready = 1'b1;
            @(posedge clk);
            #1;
            check_val("t3_valid_swap", valid, 1'b1);
            check_val("t3_data_swap", data, 8'hC3);
            @(posedge clk);
            #1;
            check_val("t3_valid_drain", valid, 1'b0);
            ready = 1'b0;
         end
      join
      idle(5);
      check_val("t3_ov", ov_cnt - ov0, 0);
      check_val("t3_acc_cnt", acc_q.size() - a0, 2);
      check_val("t3_acc_0", acc_at(a0), 8'h3C);
      check_val("t3_acc_1", acc_at(a0 + 1), 8'hC3);

      // 4: 5-cycle glitch is ignored, then 0x5A
      ready = 1'b1;
      fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_q.size();
      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(40);
      check_val("t4_glitch_valid", valid, 1'b0);
      check_val("t4_glitch_acc", acc_q.size() - a0, 0);
      check_val("t4_glitch_fe", fe_cnt - fe0, 0);
      check_val("t4_glitch_ov", ov_cnt - ov0, 0);
      send_byte(8'h5A, 1'b1);
      idle(5);
      check_val("t4_acc_cnt", acc_q.size() - a0, 1);
      check_val("t4_acc_byte", acc_at(a0), 8'h5A);

      // 5: 0x81 with low stop bit and a 100-cycle break, then 0x42
      fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_q.size();
      send_byte(8'h81, 1'b0);
      idle(100);
      rx = 1'b1;
      idle(10);
      check_val("t5_fe", fe_cnt - fe0, 1);
      check_val("t5_no_valid", acc_q.size() - a0, 0);
      send_byte(8'h42, 1'b1);
      idle(5);
      check_val("t5_fe_after", fe_cnt - fe0, 1);
      check_val("t5_ov", ov_cnt - ov0, 0);
      check_val("t5_acc_cnt", acc_q.size() - a0, 1);
      check_val("t5_acc_byte", acc_at(a0), 8'h42);

      // 6: reset during bit 4 of 0xF0 (upper bits high, no false restart)
      fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_q.size();
      fork
         send_byte(8'hF0, 1'b1);
         begin
            repeat (5 * CPB + 12) @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check_val("t6_rst_data", data, 8'h00);
            check_val("t6_rst_valid", valid, 1'b0);
            check_val("t6_rst_fe", frame_err, 1'b0);
            check_val("t6_rst_ov", overrun, 1'b0);
         end
      join
      idle(20);
      check_val("t6_abort_acc", acc_q.size() - a0, 0);
      check_val("t6_abort_fe", fe_cnt - fe0, 0);
      send_byte(8'h99, 1'b1);
      idle(5);
      check_val("t6_acc_cnt", acc_q.size() - a0, 1);
      check_val("t6_acc_byte", acc_at(a0), 8'h99);
      check_val("t6_ov", ov_cnt - ov0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
